seg7_scan_mux: RTL and testbench



---
 rtl/seg7_scan_mux_if.sv | 32 +++
 rtl/seg7_scan_mux.sv | 189 ++++++++++++++++++
 tb/tb_seg7_scan_mux.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_mux_if.sv
// Display-side bundle for the multiplexed seven-segment driver.
// The master side supplies the scan clock, the BCD word and the decimal-point
// requests. The slave side (the driver) returns the anode, segment and
// decimal-point lines.
interface seg7_scan_mux_if #(
   parameter int DIGITS = 4
);
   logic                  scan_clk;
   logic [4*DIGITS-1:0]   bcd_in;
   logic [DIGITS-1:0]     dp_in;
   logic [DIGITS-1:0]     an;
   logic [6:0]            seg;
   logic                  dp;

   modport master (
      output scan_clk,
      output bcd_in,
      output dp_in,
      input  an,
      input  seg,
      input  dp
   );

   modport slave (
      input  scan_clk,
      input  bcd_in,
      input  dp_in,
      output an,
      output seg,
      output dp
   );
endinterface

// File: rtl/seg7_scan_mux.sv
// Multiplexed seven-segment driver.
// The slow scan clock is sampled as data and edge-detected, and it steps a
// digit index. A shadow copy of the BCD word is taken once per frame so that
// every frame shows one coherent value. Leading zeros can be blanked, and all
// display lines are registered.
module seg7_scan_mux #(
   parameter int DIGITS     = 4,
   parameter bit BLANK_LZ   = 1'b1,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   seg7_scan_mux_if.slave      disp_io
);

   localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

   // Polarity masks. XOR-ing an active-high value with these gives the pin level.
   localparam logic [DIGITS-1:0] AN_POL  = {DIGITS{ACTIVE_LOW}};
   localparam logic [6:0]        SEG_POL = {7{ACTIVE_LOW}};
   localparam logic              DP_POL  = ACTIVE_LOW;

   // ------------------------------------------------------------------
   // Scan-clock synchroniser and rising-edge detector
   // ------------------------------------------------------------------
   logic       s1_q, s2_q, s3_q;
   logic       armed_q;
   logic [1:0] prime_q;
   logic       tick;

   // Three-stage sampler. armed blocks edges until a real low level is seen.
   // s2 holds a genuine sample of scan_clk only two clocks after reset
   // (prime_q tracks this). Arming earlier would mistake the reset value of
   // s2 for a low level. A scan_clk that is already high at reset release
   // would then produce a false tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         armed_q <= 1'b0;
         prime_q <= 2'b00;
      end else begin
         s1_q    <= disp_io.scan_clk;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         prime_q <= {prime_q[0], 1'b1};
         armed_q <= armed_q | (prime_q[1] & ~s2_q);
      end
   end

   assign tick = armed_q & s2_q & ~s3_q;

   // ------------------------------------------------------------------
   // Digit index and frame shadow registers
   // ------------------------------------------------------------------
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
   logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic                frame_load;

   assign frame_load = tick & (idx_q == LAST_IDX);

   // Step the index on each tick. On the wrap tick, latch the next frame.
   always_comb begin
      idx_d        = idx_q;
      shadow_bcd_d = shadow_bcd_q;
      shadow_dp_d  = shadow_dp_q;
      if (tick) begin
         if (idx_q == LAST_IDX) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
      if (frame_load) begin
         shadow_bcd_d = disp_io.bcd_in;
         shadow_dp_d  = disp_io.dp_in;
      end
   end

   // State register for the index and the frame shadow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q        <= '0;
         shadow_bcd_q <= '0;
         shadow_dp_q  <= '0;
      end else begin
         idx_q        <= idx_d;
         shadow_bcd_q <= shadow_bcd_d;
         shadow_dp_q  <= shadow_dp_d;
      end
   end

   // ------------------------------------------------------------------
   // Per-digit view of the shadow word
   // ------------------------------------------------------------------
   logic [3:0]        digit_w [DIGITS];
   logic [DIGITS-1:0] zero_w;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_w[gi] = shadow_bcd_q[4*gi +: 4];
      assign zero_w[gi]  = (shadow_bcd_q[4*gi +: 4] == 4'd0);
   end

   // Leading-zero blanking. Walk down from the most significant digit.
   // Blanking continues only while each digit is zero with no decimal point.
   // Digit 0 always stays lit.
   logic [DIGITS-1:0] blank_w;
   logic              run_zero;

   // Blanking mask computed from the shadow registers.
   always_comb begin
      blank_w  = '0;
      run_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         run_zero   = run_zero & zero_w[i] & ~shadow_dp_q[i];
         blank_w[i] = BLANK_LZ & (i != 0) & run_zero;
      end
   end

   // ------------------------------------------------------------------
   // Segment decode (active-high, segments {g,f,e,d,c,b,a})
   // ------------------------------------------------------------------
   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;   // invalid BCD shows a dash
      endcase
      return s;
   endfunction

   // ------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------
   logic [3:0]        cur_digit;
   logic [DIGITS-1:0] an_act;
   logic [6:0]        seg_act;
   logic              dp_act;
   logic [DIGITS-1:0] an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;

   // Build the active-high view of the current slot, then apply polarity.
   // A single index drives an_act, so at most one anode can be active.
   always_comb begin
      cur_digit = digit_w[idx_q];
      an_act    = '0;
      seg_act   = '0;
      dp_act    = 1'b0;
      if (!blank_w[idx_q]) begin
         an_act[idx_q] = 1'b1;
         seg_act       = decode(cur_digit);
         dp_act        = shadow_dp_q[idx_q];
      end
      an_d  = an_act ^ AN_POL;
      seg_d = seg_act ^ SEG_POL;
      dp_d  = dp_act ^ DP_POL;
   end

   // Registered display lines. Reset forces every line to its inactive level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_q  <= AN_POL;
         seg_q <= SEG_POL;
         dp_q  <= DP_POL;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign disp_io.an  = an_q;
   assign disp_io.seg = seg_q;
   assign disp_io.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux.
// Two instances share clock, reset and stimulus: one with leading-zero
// blanking and one without. Both are active-low.
module tb_seg7_scan_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic        scan_clk;
   logic [15:0] bcd;
   logic [3:0]  dpr;

   int n_total = 0;
   int n_pass  = 0;
   int cur_idx = 0;
   logic [3:0] an_e3, an_e4;
   bit onehot_bad = 1'b0;

   seg7_scan_mux_if #(.DIGITS(4)) bus_lz ();
   seg7_scan_mux_if #(.DIGITS(4)) bus_nz ();

   assign bus_lz.scan_clk = scan_clk;
   assign bus_lz.bcd_in   = bcd;
   assign bus_lz.dp_in    = dpr;
   assign bus_nz.scan_clk = scan_clk;
   assign bus_nz.bcd_in   = bcd;
   assign bus_nz.dp_in    = dpr;

   seg7_scan_mux #(.DIGITS(4), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b1)) dut_lz (
      .clk     (clk),
      .rst     (rst),
      .disp_io (bus_lz)
   );

   seg7_scan_mux #(.DIGITS(4), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b1)) dut_nz (
      .clk     (clk),
      .rst     (rst),
      .disp_io (bus_nz)
   );

   always #5 clk = ~clk;

   // Record any moment at which two anodes are low together.
   always @(negedge clk) begin
      if ($countones(~bus_lz.an) > 1 || $countones(~bus_nz.an) > 1)
         onehot_bad = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic expect_digit(input string tag, input bit use_nz,
                               input logic [3:0] an_x, input logic [6:0] seg_x, input logic dp_x);
      if (use_nz) begin
         check({tag, ".nz.an"},  32'(bus_nz.an),  32'(an_x));
         check({tag, ".nz.seg"}, 32'(bus_nz.seg), 32'(seg_x));
         check({tag, ".nz.dp"},  32'(bus_nz.dp),  32'(dp_x));
      end else begin
         check({tag, ".lz.an"},  32'(bus_lz.an),  32'(an_x));
         check({tag, ".lz.seg"}, 32'(bus_lz.seg), 32'(seg_x));
         check({tag, ".lz.dp"},  32'(bus_lz.dp),  32'(dp_x));
      end
   endtask

   // One scan_clk period of 20 clk. The rise is sampled at E1. an_e3 and
   // an_e4 capture the anodes just after E3 and E4.
   task automatic scan_pulse();
      @(negedge clk);
      scan_clk = 1'b1;
      repeat (3) @(posedge clk);
      #1 an_e3 = bus_nz.an;
      @(posedge clk);
      #1 an_e4 = bus_nz.an;
      repeat (5) @(posedge clk);
      @(negedge clk);
      scan_clk = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      cur_idx = (cur_idx + 1) % 4;
      $display("pulse idx=%0d an_lz=%h seg_lz=%h an_nz=%h seg_nz=%h",
               cur_idx, bus_lz.an, bus_lz.seg, bus_nz.an, bus_nz.seg);
   endtask

   // Advance to the wrap so that the current bcd/dp values are latched.
   task automatic goto_frame();
      while (cur_idx != 3) scan_pulse();
      scan_pulse();
   endtask

   logic [3:0] an_tab  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
   logic [6:0] s1234   [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
   logic [6:0] s0005   [4] = '{7'h12, 7'h40, 7'h40, 7'h7F};
   logic [3:0] a0005   [4] = '{4'hE, 4'hD, 4'hB, 4'hF};
   logic       d0005   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      rst      = 1'b1;
      scan_clk = 1'b0;
      bcd      = 16'h0000;
      dpr      = 4'b0000;
      repeat (3) @(posedge clk);
      #1 expect_digit("reset", 1'b0, 4'hF, 7'h7F, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      cur_idx = 0;
      repeat (2) @(posedge clk);
      #1 expect_digit("post_reset", 1'b0, 4'hE, 7'h40, 1'b1);

      // 1234: latency, digit order, both instances.
      bcd = 16'h1234;
      goto_frame();
      check("lat0.e3", 32'(an_e3), 32'(4'h7));
      check("lat0.e4", 32'(an_e4), 32'(4'hE));
      expect_digit("d1234_0", 1'b0, 4'hE, 7'h19, 1'b1);
      for (int i = 1; i < 4; i++) begin
         scan_pulse();
         check($sformatf("lat%0d.e3", i), 32'(an_e3), 32'(an_tab[i-1]));
         check($sformatf("lat%0d.e4", i), 32'(an_e4), 32'(an_tab[i]));
         expect_digit($sformatf("d1234_%0d", i), 1'b0, an_tab[i], s1234[i], 1'b1);
         expect_digit($sformatf("d1234_%0d", i), 1'b1, an_tab[i], s1234[i], 1'b1);
      end

      // Mid-scan reset with digit 3 lit, then release with scan_clk high.
      @(negedge clk);
      rst = 1'b1;
      #1 expect_digit("mid_reset", 1'b0, 4'hF, 7'h7F, 1'b1);
      scan_clk = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cur_idx = 0;
      repeat (30) @(posedge clk);
      #1 expect_digit("hold_high", 1'b1, 4'hE, 7'h40, 1'b1);
      @(negedge clk);
      scan_clk = 1'b0;
      repeat (10) @(posedge clk);
      scan_pulse();
      expect_digit("first_step", 1'b1, 4'hD, 7'h40, 1'b1);
      expect_digit("first_step", 1'b0, 4'hF, 7'h7F, 1'b1);

      // 0007: blanking versus no blanking.
      bcd = 16'h0007;
      goto_frame();
      expect_digit("d0007_0", 1'b0, 4'hE, 7'h78, 1'b1);
      expect_digit("d0007_0", 1'b1, 4'hE, 7'h78, 1'b1);
      for (int i = 1; i < 4; i++) begin
         scan_pulse();
         expect_digit($sformatf("d0007_%0d", i), 1'b0, 4'hF, 7'h7F, 1'b1);
         expect_digit($sformatf("d0007_%0d", i), 1'b1, an_tab[i], 7'h40, 1'b1);
      end

      // 0000: only digit 0 stays lit.
      bcd = 16'h0000;
      goto_frame();
      expect_digit("d0000_0", 1'b0, 4'hE, 7'h40, 1'b1);
      for (int i = 1; i < 4; i++) begin
         scan_pulse();
         expect_digit($sformatf("d0000_%0d", i), 1'b0, 4'hF, 7'h7F, 1'b1);
      end

      // 0005 with dp on digit 2.
      bcd = 16'h0005;
      dpr = 4'b0100;
      goto_frame();
      expect_digit("dp_0", 1'b0, a0005[0], s0005[0], d0005[0]);
      for (int i = 1; i < 4; i++) begin
         scan_pulse();
         expect_digit($sformatf("dp_%0d", i), 1'b0, a0005[i], s0005[i], d0005[i]);
      end

      // Frame coherence: change the word while idx=1.
      bcd = 16'h1111;
      dpr = 4'b0000;
      goto_frame();
      expect_digit("coh_a0", 1'b0, 4'hE, 7'h79, 1'b1);
      scan_pulse();
      expect_digit("coh_a1", 1'b0, 4'hD, 7'h79, 1'b1);
      bcd = 16'h2222;
      for (int i = 2; i < 4; i++) begin
         scan_pulse();
         expect_digit($sformatf("coh_a%0d", i), 1'b0, an_tab[i], 7'h79, 1'b1);
      end
      for (int i = 0; i < 4; i++) begin
         scan_pulse();
         expect_digit($sformatf("coh_b%0d", i), 1'b0, an_tab[i], 7'h24, 1'b1);
      end

      // Invalid code on digit 1.
      bcd = 16'h00A0;
      goto_frame();
      expect_digit("inv_0", 1'b0, 4'hE, 7'h40, 1'b1);
      scan_pulse();
      expect_digit("inv_1", 1'b0, 4'hD, 7'h3F, 1'b1);
      scan_pulse();
      expect_digit("inv_2", 1'b0, 4'hF, 7'h7F, 1'b1);
      expect_digit("inv_2", 1'b1, 4'hB, 7'h40, 1'b1);

      check("onehot", 32'(onehot_bad), 32'(1'b0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
